// File: rtl/amp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amp_pkg
// Brief    : Shared helpers for the amplifier output path (duty conversion).
// Revision : 1.0 - initial release
// ============================================================================
package amp_pkg;

  // Mid-scale code of an n-bit unsigned duty value: the "silence" level.
  function automatic logic [31:0] midscale(input int n);
    midscale = 32'd1 << (n - 1);
  endfunction

  // Attenuate, convert to offset binary, round to n bits and saturate.
  // The sample sits in the low sw bits of 'sample' and is sign-extended here.
  // Valid for n < sw < 64 and n <= 31.
  function automatic logic [31:0] sample_to_duty(input logic [63:0] sample,
                                                 input logic [2:0]  attn,
                                                 input int          sw,
                                                 input int          n);
    logic signed [63:0] s;
    logic [63:0]        mask_sw;
    logic [64:0]        u;
    logic [64:0]        r;
    logic [31:0]        mask_n;
    s       = $signed(sample << (64 - sw)) >>> (64 - sw);
    s       = s >>> attn;
    mask_sw = (64'd1 << sw) - 64'd1;
    u       = {1'b0, $unsigned(s) & mask_sw} ^ (65'd1 << (sw - 1));
    r       = u + (65'd1 << (sw - n - 1));
    mask_n  = (32'd1 << n) - 32'd1;
    if (r[sw]) begin
      sample_to_duty = mask_n;
    end else begin
      sample_to_duty = 32'(r >> (sw - n)) & mask_n;
    end
  endfunction

endpackage : amp_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count and combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard against overflow/underflow locally so a misbehaving caller cannot
  // corrupt the pointers.
  assign w_do_push = push & (r_level != c_aw'(0) + (c_aw+1)'(DEPTH)) ;
  assign w_do_pop  = pop & (r_level != '0);

  assign full  = (r_level == (c_aw+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_aw'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_aw'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (c_aw+1)'(1);
        2'b01:   r_level <= r_level - (c_aw+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/pwm_duty_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_feeder
// Brief    : Buffers PCM samples and loads PWM duty at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_feeder
  import amp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int N            = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [SAMPLE_WIDTH-1:0]       in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    attn,
  input  logic                          period_start,
  output logic [N-1:0]                  duty,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam logic [N-1:0] c_mid = N'(midscale(N));

  logic [SAMPLE_WIDTH-1:0] w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_tick;
  logic [N-1:0]            w_conv;
  logic [N-1:0]            r_duty;
  logic                    r_underflow;

  assign in_ready = ena & ~rst & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_tick   = ena & period_start;
  assign w_pop    = w_tick & ~w_empty;
  assign w_conv   = N'(sample_to_duty(64'(w_head), attn, SAMPLE_WIDTH, N));

  sync_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_sample),
    .rdata (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Empty is registered, so a push landing on the same tick still underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty      <= c_mid;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_tick & w_empty;
      if (w_tick) begin
        r_duty <= w_empty ? c_mid : w_conv;
      end
    end
  end

  assign duty      = r_duty;
  assign underflow = r_underflow;

endmodule : pwm_duty_feeder
`default_nettype wire
